// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared state encoding and width helper for the divider
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divmod_if.sv
// rtl/divmod_if.sv - request/result bundle between a requester and the divider
interface divmod_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, a, b,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, a, b,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/divmod_step.sv
// rtl/divmod_step.sv - one combinational restoring shift-subtract iteration
module divmod_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // r < b always holds, so the borrow bit of trial is a reliable sign
  assign r_sh   = {r, q[WIDTH-1]};
  assign trial  = r_sh - {1'b0, b};
  assign r_next = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/divmod_unit.sv
// rtl/divmod_unit.sv - multi-cycle unsigned divider with quotient, remainder and divide-by-zero flag
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     reset,
  divmod_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic             dbz;

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b      (b_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = (bus.b == '0) ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // q_reg doubles as the dividend shift register, so results live in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      b_reg <= '0;
      dbz   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.b == '0) begin
              q_reg <= '1;
              r_reg <= bus.a;
              dbz   <= 1'b1;
            end else begin
              q_reg <= bus.a;
              r_reg <= '0;
              b_reg <= bus.b;
              cnt   <= CNT_W'(WIDTH);
              dbz   <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz;
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;

endmodule

// File: tb/tb_divmod_unit.sv
// tb/tb_divmod_unit.sv - scoreboard bench for 8- and 16-bit divider builds
module tb_divmod_unit;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   run8 = 0;
  int   run16 = 0;
  exp_t q8[$];
  exp_t q16[$];

  divmod_if #(.WIDTH(8))  bus8 ();
  divmod_if #(.WIDTH(16)) bus16 ();

  divmod_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  divmod_unit #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input int k);
    exp_t        e;
    logic [31:0] mask;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.a   = a & mask;
    e.b   = b & mask;
    if (e.b == 0) begin
      e.q        = mask;
      e.r        = e.a;
      e.dbz      = 1'b1;
      e.done_cyc = k;
      e.busy_len = 1;
    end else begin
      e.q        = e.a / e.b;
      e.r        = e.a % e.b;
      e.dbz      = 1'b0;
      e.done_cyc = k + w;
      e.busy_len = w + 1;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [31:0] q,
                         input logic [31:0] r, input logic dbz, input int run);
    check({tag, "_quotient"}, q, e.q);
    check({tag, "_remainder"}, r, e.r);
    check({tag, "_div_by_zero"}, dbz, e.dbz);
    check({tag, "_done_cycle"}, cyc, e.done_cyc);
    check({tag, "_busy_len"}, run, e.busy_len);
    if (!e.dbz) begin
      check({tag, "_qb_plus_r"}, 64'(q) * 64'(e.b) + 64'(r), 64'(e.a));
      check({tag, "_r_lt_b"}, r < e.b, 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset || !bus8.busy) run8 = 0;
    else run8 = run8 + 1;
    if (bus8.done) begin
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else compare("w8", q8.pop_front(), 32'(bus8.quotient), 32'(bus8.remainder), bus8.div_by_zero, run8);
    end
  end

  always @(negedge clk) begin
    if (reset || !bus16.busy) run16 = 0;
    else run16 = run16 + 1;
    if (bus16.done) begin
      if (q16.size() == 0) check("done16_unexpected", 1, 0);
      else compare("w16", q16.pop_front(), 32'(bus16.quotient), 32'(bus16.remainder), bus16.div_by_zero, run16);
    end
  end

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? bus8.busy : bus16.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", n < 100, 1);
  endtask

  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b);
    wait_idle(sel);
    if (sel == 0) begin
      bus8.start = 1'b1;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      q8.push_back(model(8, a, b, cyc + 1));
    end else begin
      bus16.start = 1'b1;
      bus16.a     = a[15:0];
      bus16.b     = b[15:0];
      q16.push_back(model(16, a, b, cyc + 1));
    end
    @(posedge clk);
    #1;
    // scramble operands after capture to prove they are latched
    if (sel == 0) begin
      bus8.start = 1'b0;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
    end else begin
      bus16.start = 1'b0;
      bus16.a     = 16'($urandom);
      bus16.b     = 16'($urandom);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    bus8.start  = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_dbz", bus8.div_by_zero, 0);
    check("rst_quotient", bus8.quotient, 0);
    check("rst_remainder", bus8.remainder, 0);
    @(negedge clk);
    reset = 1'b0;

    issue(0, 17, 5);
    issue(0, 5, 17);
    issue(0, 255, 1);
    issue(0, 255, 255);
    issue(0, 42, 0);

    issue(0, 100, 7);
    repeat (2) @(posedge clk);
    #1;
    bus8.start = 1'b1;
    bus8.a     = 8'd9;
    bus8.b     = 8'd3;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    issue(0, 9, 3);

    // abort mid-calculation with an asynchronous reset between edges
    wait_idle(0);
    bus8.start = 1'b1;
    bus8.a     = 8'd200;
    bus8.b     = 8'd13;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_dbz", bus8.div_by_zero, 0);
    check("abort_quotient", bus8.quotient, 0);
    check("abort_remainder", bus8.remainder, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    issue(0, 200, 13);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      issue(0, ra, rb);
    end

    issue(1, 50000, 123);
    issue(1, 0, 0);
    issue(1, 65535, 1);
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      issue(1, ra, rb);
    end

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_q8", q8.size(), 0);
    check("drain_q16", q16.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divmod_unit.md
Name: divmod_unit

Overview:
- Parametrised multi-cycle unsigned divider. It generalises the earlier mod controller into a combined control and datapath block.
- It produces both quotient and remainder of A / B using restoring shift-subtract division, one bit per cycle.
- Latency is fixed and does not depend on the operand values.
- It adds divide-by-zero detection and a busy/done handshake.
- It sits beside the ALU as a slow-path arithmetic unit for DIV/MOD instructions.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width. This is derived and must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  dividend; captured on the accepting edge.
- b  in  WIDTH  divisor; captured on the accepting edge.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- div_by_zero  out  1  set with done when the captured b == 0; held with the results.
- quotient  out  WIDTH  a / b (unsigned).
- remainder  out  WIDTH  a % b (unsigned).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient, remainder and the counter all go to 0.
- States: IDLE, CALC, DONE. Encode them in the shared package.
- IDLE, start == 1 and b != 0:
  - Latch a into the quotient/shift register, b into the divisor register, and clear the partial remainder.
  - Set counter = WIDTH, clear div_by_zero, go to CALC.
- IDLE, start == 1 and b == 0:
  - Go directly to DONE.
  - quotient = all ones, remainder = a, div_by_zero = 1.
- IDLE, start == 0: stay in IDLE; all outputs hold their last values.
- CALC, each cycle:
  - Form {R,Q} shifted left by one.
  - Compute trial = R_shifted - B, evaluated at WIDTH+1 bits.
  - If trial is non-negative, R = trial and Q[0] = 1. Otherwise R = R_shifted and Q[0] = 0.
  - Decrement the counter. On the edge where the counter goes 1 -> 0, go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - With start sampled at edge 0, done is high in the cycle following edge WIDTH.
  - For b == 0, done is high in the cycle following edge 0.
- quotient and remainder are driven from internal registers.
  - During CALC they show intermediate values and are undefined to consumers.
  - They are stable and correct from the done cycle until the next accepted start.
- start while busy is ignored. It is not queued, and a held start is re-sampled only once the block is back in IDLE.
  - Back-to-back operation: start held high at the done cycle is accepted on the edge leaving DONE? No. It is accepted on the first edge in IDLE, so there is one idle cycle minimum between operations.
- a and b may change freely after the accepting edge without affecting the result.
- Reset asserted mid-CALC aborts the operation. No done is produced, and all outputs return to 0.
- Arithmetic is unsigned only. Signed support is out of scope.

Decomposition:
- divmod_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - a function computing CNT_W from WIDTH.
- One natural sub-module: divmod_step. It is purely combinational and performs one restoring iteration (inputs R, Q, B; outputs R_next, Q_next).
  - Keeping it separate lets a later revision unroll two steps per cycle.
- The FSM and registers stay in divmod_unit.

Test Plan:
- WIDTH=8, a=17, b=5, start pulse -> done 8 cycles after the accepting edge, quotient=3, remainder=2, div_by_zero=0, busy high for exactly 9 cycles.
- a=5, b=17 -> quotient=0, remainder=5. Then a=255, b=1 -> quotient=255, remainder=0. Then a=255, b=255 -> quotient=1, remainder=0.
- a=42, b=0 -> done in the next cycle, div_by_zero=1, quotient=8'hFF, remainder=42, busy high for 1 cycle.
- Start a=100, b=7, then pulse start with a=9, b=3 at cycle 3 -> second request ignored, result quotient=14, remainder=2. A subsequent start in IDLE yields quotient=3, remainder=0.
- Assert reset asynchronously mid-CALC (between clock edges) at cycle 4 -> all outputs 0 immediately. No done pulse ever appears, and the next start computes correctly.
- WIDTH=16 build, a=50000, b=123 -> done after 16 cycles, quotient=406, remainder=62. Also run a randomised sweep checking q*b + r == a and r < b.
